axis_framer: RTL
================

AXIS_FRAMER -- requirements
Module: axis_framer

Interface
REQ-001 The block SHALL have parameter DW, default 64, giving the data width of both streams in bits.
REQ-002 The block SHALL have parameter LEN_W, default 10, giving the width of frame_len and of the internal beat counter.
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have the port s_rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-005 The block SHALL have the port stream_in, axis_if.in, DW-bit data plus vld/rdy/last, carrying the unframed input beats; stream_in.last SHALL be ignored.
REQ-006 The block SHALL have the port stream_out, axis_if.out, DW-bit data plus vld/rdy/last, carrying the framed beats to the downstream frame-dump sink.
REQ-007 The block SHALL have the port frame_len, input, LEN_W bits, giving the beats per frame; 0 SHALL be treated as 1.
REQ-008 The block SHALL have the port frame_cnt, output, 16 bits, counting the frames completed on stream_out.

Function
REQ-009 A transfer SHALL occur on either stream only in a cycle where vld and rdy are both 1 at the rising clk edge.
REQ-010 The block SHALL hold a 2-entry buffer (output register plus skid register); stream_in.rdy SHALL be driven from a register and SHALL be 1 exactly when the skid register is empty.
REQ-011 A beat accepted while the output register is empty, or drains in the same cycle, SHALL appear on stream_out with vld=1 in the next cycle (latency 1).
REQ-012 A beat accepted while the output register is held SHALL enter the skid register; stream_in.rdy SHALL be 0 from the next cycle until the skid entry moves to the output register.
REQ-013 While stream_out.vld=1 and stream_out.rdy=0, stream_out.data and stream_out.last SHALL remain stable and vld SHALL remain 1.
REQ-014 Beats SHALL leave in acceptance order, with no loss and no duplication, under any vld/rdy pattern.
REQ-015 The block SHALL keep beat_idx (LEN_W bits), the count of beats accepted in the current frame, starting at 0.
REQ-016 The effective length L SHALL equal max(frame_len, 1), sampled in the cycle the frame's first beat is accepted (beat_idx=0) and held until the frame ends.
REQ-017 Changes to frame_len after a frame's first beat SHALL NOT affect that frame.
REQ-018 An accepted beat SHALL be tagged last=1 exactly when beat_idx = L-1; beat_idx SHALL then return to 0, otherwise it SHALL increment by 1.
REQ-019 With L=1, every beat SHALL carry last=1.
REQ-020 frame_cnt SHALL increment by 1 in the cycle a beat with last=1 transfers on stream_out, and SHALL wrap from 0xFFFF to 0x0000.
REQ-021 The block SHALL have no idle timeout and no early flush; a partial frame SHALL wait indefinitely for input.
REQ-022 Simultaneous events: if an input accept and an output drain occur in the same cycle, both SHALL complete, and buffer occupancy SHALL be unchanged.

Reset
REQ-023 While s_rst_n=0, the following SHALL be asynchronously forced: stream_in.rdy=0, stream_out.vld=0, stream_out.last=0, stream_out.data=0, frame_cnt=0, beat_idx=0, both buffer entries empty.
REQ-024 stream_in.rdy SHALL first be 1 on the first rising clk edge after s_rst_n deasserts.
REQ-025 Reset asserted mid-frame SHALL discard buffered beats and the partial frame; the first beat after reset SHALL start a new frame.

Verification
REQ-026 Bench scenario, basic framing: frame_len=4, 8 consecutive beats 0..7, stream_out.rdy=1 throughout -> last=1 on beats 3 and 7 only, each beat 1 cycle after acceptance, frame_cnt=2.
REQ-027 Bench scenario, backpressure: frame_len=3, continuous input, stream_out.rdy toggling 1,0,0,1 repeating -> stream_in.rdy falls within 2 accepts, data on stalled cycles is stable, output order is 0,1,2,... with no gaps or repeats.
REQ-028 Bench scenario, zero length: frame_len=0, 3 beats -> all 3 carry last=1 and frame_cnt=3.
REQ-029 Bench scenario, length change mid-frame: frame_len=5, change to 2 after beat 1 -> last on beat 4; the next frame uses L=2, so last falls on beats 6 and 8.
REQ-030 Bench scenario, reset mid-frame: frame_len=4, 2 beats accepted with output stalled, assert s_rst_n=0 -> all outputs 0 immediately; after release, 4 new beats give last on the 4th and frame_cnt=1.
REQ-031 Bench scenario, counter wrap: preload 65535 frames with frame_len=1, then send 1 more beat -> frame_cnt=0x0000.

Source files
------------

// File: rtl/axis_framer_if.sv
// AXI-Stream style handshake bundle: data plus vld/rdy/last.
// The "in" view is what a consumer sees; the "out" view is what a producer drives.
interface axis_if #(
  parameter int DW = 64
);
  logic [DW-1:0] data;
  logic          vld;
  logic          rdy;
  logic          last;

  modport in  (input data, input vld, input last, output rdy);
  modport out (output data, output vld, output last, input rdy);
endinterface

// File: rtl/axis_framer.sv
// Stream framer: tags every L-th accepted beat with last through a 2-entry
// output/skid buffer and counts frames completed downstream.
module axis_framer #(
  parameter int DW    = 64,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             s_rst_n,
  axis_if.in               stream_in,
  axis_if.out              stream_out,
  input  logic [LEN_W-1:0] frame_len,
  output logic [15:0]      frame_cnt
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic             in_rdy_r,    in_rdy_s;
  logic             out_vld_r,   out_vld_s;
  logic [DW-1:0]    out_data_r,  out_data_s;
  logic             out_last_r,  out_last_s;
  logic             skid_vld_r,  skid_vld_s;
  logic [DW-1:0]    skid_data_r, skid_data_s;
  logic             skid_last_r, skid_last_s;
  logic [LEN_W-1:0] beat_idx_r,  beat_idx_s;
  logic [LEN_W-1:0] len_r,       len_s;
  logic [15:0]      frame_cnt_r, frame_cnt_s;

  logic             accept_s;
  logic             drain_s;
  logic [LEN_W-1:0] len_eff_s;
  logic             tag_last_s;
  logic             unused_last_s;

  // The input last flag carries no meaning here; frames are rebuilt from the beat count.
  assign unused_last_s = stream_in.last;

  // Handshakes, last tagging and next state of the buffer, beat counter and frame counter.
  always_comb begin
    accept_s    = stream_in.vld & in_rdy_r;
    drain_s     = out_vld_r & stream_out.rdy;
    out_vld_s   = out_vld_r;
    out_data_s  = out_data_r;
    out_last_s  = out_last_r;
    skid_vld_s  = skid_vld_r;
    skid_data_s = skid_data_r;
    skid_last_s = skid_last_r;
    beat_idx_s  = beat_idx_r;
    len_s       = len_r;
    frame_cnt_s = frame_cnt_r;

    // Length is latched on a frame's first beat so later frame_len edits wait for the next frame.
    if (beat_idx_r == LEN_ZERO) begin
      len_eff_s = (frame_len == LEN_ZERO) ? LEN_ONE : frame_len;
    end else begin
      len_eff_s = len_r;
    end
    tag_last_s = (beat_idx_r == (len_eff_s - LEN_ONE));

    if (accept_s) begin
      len_s      = len_eff_s;
      beat_idx_s = tag_last_s ? LEN_ZERO : (beat_idx_r + LEN_ONE);
    end else begin
      len_s      = len_r;
    end

    if (!out_vld_r || drain_s) begin
      if (skid_vld_r) begin
        out_vld_s  = 1'b1;
        out_data_s = skid_data_r;
        out_last_s = skid_last_r;
        skid_vld_s = 1'b0;
      end else if (accept_s) begin
        out_vld_s  = 1'b1;
        out_data_s = stream_in.data;
        out_last_s = tag_last_s;
      end else begin
        out_vld_s  = 1'b0;
      end
    end else begin
      // Output is held: a beat accepted now parks in the skid register.
      if (accept_s) begin
        skid_vld_s  = 1'b1;
        skid_data_s = stream_in.data;
        skid_last_s = tag_last_s;
      end else begin
        skid_vld_s  = skid_vld_r;
      end
    end

    in_rdy_s = ~skid_vld_s;

    if (drain_s && out_last_r) begin
      frame_cnt_s = frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_s = frame_cnt_r;
    end
  end

  // State registers; reset empties both buffer entries and abandons any partial frame.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      in_rdy_r    <= 1'b0;
      out_vld_r   <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_last_r  <= 1'b0;
      skid_vld_r  <= 1'b0;
      skid_data_r <= {DW{1'b0}};
      skid_last_r <= 1'b0;
      beat_idx_r  <= LEN_ZERO;
      len_r       <= LEN_ONE;
      frame_cnt_r <= 16'd0;
    end else begin
      in_rdy_r    <= in_rdy_s;
      out_vld_r   <= out_vld_s;
      out_data_r  <= out_data_s;
      out_last_r  <= out_last_s;
      skid_vld_r  <= skid_vld_s;
      skid_data_r <= skid_data_s;
      skid_last_r <= skid_last_s;
      beat_idx_r  <= beat_idx_s;
      len_r       <= len_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  assign stream_in.rdy   = in_rdy_r;
  assign stream_out.vld  = out_vld_r;
  assign stream_out.data = out_data_r;
  assign stream_out.last = out_last_r;
  assign frame_cnt       = frame_cnt_r;

endmodule
